uart_rx: RTL and testbench

- Serial receive front-end of the UART. Deserialises the `rx` line into bytes and pushes each byte into the RX queue's write port (`di`/`we`).
- Runs on the system clock and advances only on the 16x-oversampling strobe produced by the UART main-clock divider.
- Frame format (data bits, parity, stop bits) comes from config register B fields.
- Reports framing, parity and overrun errors as single-cycle pulses for the status/IRQ logic.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_bit_synchronizer.sv | 28 ++
 rtl/uart_rx.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int DATA_BITS_BASE = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2,
      ST_BREAK
   } uart_rx_state_t;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_EVEN = 2'd1,
      PARITY_ODD  = 2'd2
   } parity_t;

   // Encoding 3 is reserved and behaves like "no parity".
   function automatic logic parity_enabled(input logic [1:0] mode);
      return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
   endfunction

endpackage

// File: rtl/uart_rx_bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous input, with a
// configurable reset value so idle-high lines come out of reset inactive.
module bit_synchronizer #(
   parameter int   STAGES      = 2,
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chain <= {STAGES{RESET_VALUE}};
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receive front-end: oversampled start detection, mid-bit sampling,
// optional parity and one or two stop bits, with one-cycle status pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_tick,
   input  logic       rx,
   input  logic [1:0] data_bits_count,
   input  logic [1:0] parity_type,
   input  logic       double_stop_bits,
   input  logic       fifo_full,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

   logic           rxs;
   uart_rx_state_t state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic [2:0]     idx, idx_n, last_idx;
   logic [7:0]     shift, shift_n, data_n;
   logic [1:0]     cfg_bits, cfg_bits_n, cfg_par, cfg_par_n;
   logic           cfg_two, cfg_two_n;
   logic           par_acc, par_acc_n, par_bad, par_bad_n;
   logic           valid_n, ferr_n, perr_n, ovr_n;
   logic           frame_done;

   bit_synchronizer #(
      .STAGES      (SYNC_STAGES),
      .RESET_VALUE (1'b1)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (rx),
      .q     (rxs)
   );

   assign last_idx = 3'(DATA_BITS_BASE - 1) + {1'b0, cfg_bits};
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         idx        <= '0;
         shift      <= '0;
         cfg_bits   <= '0;
         cfg_par    <= '0;
         cfg_two    <= 1'b0;
         par_acc    <= 1'b0;
         par_bad    <= 1'b0;
         data       <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         shift      <= shift_n;
         cfg_bits   <= cfg_bits_n;
         cfg_par    <= cfg_par_n;
         cfg_two    <= cfg_two_n;
         par_acc    <= par_acc_n;
         par_bad    <= par_bad_n;
         data       <= data_n;
         data_valid <= valid_n;
         frame_err  <= ferr_n;
         parity_err <= perr_n;
         overrun    <= ovr_n;
      end
   end

   // Everything except the output pulses moves only on sample ticks; the
   // frame is judged on the mid-stop-bit sample so a following start edge
   // is still seen from IDLE.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = idx;
      shift_n    = shift;
      cfg_bits_n = cfg_bits;
      cfg_par_n  = cfg_par;
      cfg_two_n  = cfg_two;
      par_acc_n  = par_acc;
      par_bad_n  = par_bad;
      data_n     = data;
      valid_n    = 1'b0;
      ferr_n     = 1'b0;
      perr_n     = 1'b0;
      ovr_n      = 1'b0;
      frame_done = 1'b0;

      if (sample_tick) begin
         case (state)
            ST_IDLE: begin
               if (!rxs) begin
                  cnt_n      = '0;
                  idx_n      = '0;
                  shift_n    = '0;
                  par_acc_n  = 1'b0;
                  par_bad_n  = 1'b0;
                  cfg_bits_n = data_bits_count;
                  cfg_par_n  = parity_type;
                  cfg_two_n  = double_stop_bits;
                  state_n    = ST_START;
               end
            end
            ST_START: begin
               if (cnt == HALF_LAST) begin
                  cnt_n   = '0;
                  state_n = rxs ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (cnt == BIT_LAST) begin
                  shift_n[idx] = rxs;
                  par_acc_n    = par_acc ^ rxs;
                  cnt_n        = '0;
                  idx_n        = idx + 3'd1;
                  if (idx == last_idx) begin
                     state_n = parity_enabled(cfg_par) ? ST_PARITY : ST_STOP1;
                  end
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            ST_PARITY: begin
               if (cnt == BIT_LAST) begin
                  par_bad_n = par_acc ^ rxs ^ (cfg_par == PARITY_ODD);
                  cnt_n     = '0;
                  state_n   = ST_STOP1;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            ST_STOP1, ST_STOP2: begin
               if (cnt == BIT_LAST) begin
                  cnt_n = '0;
                  if (!rxs) begin
                     ferr_n  = 1'b1;
                     perr_n  = par_bad;
                     state_n = ST_BREAK;
                  end else if (state == ST_STOP1 && cfg_two) begin
                     state_n = ST_STOP2;
                  end else begin
                     frame_done = 1'b1;
                  end
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            ST_BREAK: begin
               if (rxs) begin
                  state_n = ST_IDLE;
               end
            end
            default: state_n = ST_IDLE;
         endcase

         if (frame_done) begin
            state_n = ST_IDLE;
            if (par_bad) begin
               perr_n = 1'b1;
            end else if (fifo_full) begin
               ovr_n = 1'b1;
            end else begin
               valid_n = 1'b1;
               data_n  = shift;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected pulses into a
// queue, and an independent monitor matches every pulse the receiver emits.
module tb_uart_rx;

   localparam int BIT_CLKS = 64;

   typedef struct {
      logic [3:0] flags;
      logic [7:0] data;
   } ev_t;

   localparam logic [3:0] EV_VALID = 4'b1000;
   localparam logic [3:0] EV_FERR  = 4'b0100;
   localparam logic [3:0] EV_PERR  = 4'b0010;
   localparam logic [3:0] EV_OVR   = 4'b0001;

   logic       clk;
   logic       reset;
   logic       sample_tick;
   logic       rx;
   logic [1:0] data_bits_count;
   logic [1:0] parity_type;
   logic       double_stop_bits;
   logic       fifo_full;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       overrun;
   logic       busy;

   int  total = 0;
   int  bad   = 0;
   ev_t expq[$];

   uart_rx #(
      .OVERSAMPLE  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .sample_tick      (sample_tick),
      .rx               (rx),
      .data_bits_count  (data_bits_count),
      .parity_type      (parity_type),
      .double_stop_bits (double_stop_bits),
      .fifo_full        (fifo_full),
      .data             (data),
      .data_valid       (data_valid),
      .frame_err        (frame_err),
      .parity_err       (parity_err),
      .overrun          (overrun),
      .busy             (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One tick every four clocks gives 64 clocks per bit.
   initial begin
      sample_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         sample_tick = 1'b1;
         @(negedge clk);
         sample_tick = 1'b0;
      end
   end

   // Every pulse cycle is matched against the oldest expected event.
   initial begin
      ev_t e;
      logic [3:0] obs;
      forever begin
         @(negedge clk);
         obs = {data_valid, frame_err, parity_err, overrun};
         if (obs != 4'b0000) begin
            total++;
            if (expq.size() == 0) begin
               bad++;
               $display("[TB] FAIL unexpected_pulse got flags=%b data=%h want no pulse", obs, data);
            end else begin
               e = expq.pop_front();
               if (obs != e.flags || (e.flags[3] && data != e.data)) begin
                  bad++;
                  $display("[TB] FAIL pulse got flags=%b data=%h want flags=%b data=%h",
                           obs, data, e.flags, e.data);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s got=%h want=%h", name, actual, expected);
      end
   endtask

   task automatic expectEvent(input logic [3:0] flags, input logic [7:0] value);
      ev_t e;
      e.flags = flags;
      e.data  = value;
      expq.push_back(e);
   endtask

   task automatic driveBit(input logic b);
      rx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic idleBits(input int n);
      rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
   endtask

   // par_bit < 0 means no parity bit on the line.
   task automatic applyStimulus(input logic [7:0] value, input int nbits, input int par_bit,
                                input logic stop1, input logic stop2, input bit two_stop,
                                input bit check_busy);
      rx = 1'b0;
      repeat (BIT_CLKS / 2) @(negedge clk);
      if (check_busy) checkOutput("busy_start", {7'd0, busy}, 8'd1);
      repeat (BIT_CLKS / 2) @(negedge clk);
      for (int i = 0; i < nbits; i++) driveBit(value[i]);
      if (par_bit >= 0) driveBit(par_bit[0]);
      rx = stop1;
      repeat (48) @(negedge clk);
      if (check_busy) checkOutput("busy_stop", {7'd0, busy}, 8'd0);
      repeat (BIT_CLKS - 48) @(negedge clk);
      if (two_stop) driveBit(stop2);
   endtask

   initial begin
      reset            = 1'b1;
      rx               = 1'b1;
      data_bits_count  = 2'd3;
      parity_type      = 2'd0;
      double_stop_bits = 1'b0;
      fifo_full        = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("rst_data", data, 8'h00);
      checkOutput("rst_busy", {7'd0, busy}, 8'd0);
      checkOutput("rst_pulses", {4'd0, data_valid, frame_err, parity_err, overrun}, 8'd0);
      reset = 1'b0;
      idleBits(1);

      $display("[TB] 8N1 frame A5");
      expectEvent(EV_VALID, 8'hA5);
      applyStimulus(8'hA5, 8, -1, 1'b1, 1'b1, 1'b0, 1'b1);
      idleBits(2);
      checkOutput("data_hold_a5", data, 8'hA5);

      $display("[TB] 5E1 frames");
      data_bits_count = 2'd0;
      parity_type     = 2'd1;
      expectEvent(EV_VALID, 8'h16);
      applyStimulus(8'h16, 5, 1, 1'b1, 1'b1, 1'b0, 1'b0);
      idleBits(1);
      expectEvent(EV_PERR, 8'h00);
      applyStimulus(8'h16, 5, 0, 1'b1, 1'b1, 1'b0, 1'b0);
      idleBits(1);
      checkOutput("data_after_perr", data, 8'h16);

      $display("[TB] 7O2 framing error and break");
      data_bits_count  = 2'd2;
      parity_type      = 2'd2;
      double_stop_bits = 1'b1;
      expectEvent(EV_FERR, 8'h00);
      applyStimulus(8'h53, 7, 1, 1'b1, 1'b0, 1'b1, 1'b0);
      rx = 1'b0;
      repeat (25 * BIT_CLKS) @(negedge clk);
      checkOutput("busy_break", {7'd0, busy}, 8'd1);
      repeat (25 * BIT_CLKS) @(negedge clk);
      idleBits(2);
      checkOutput("idle_after_break", {7'd0, busy}, 8'd0);
      expectEvent(EV_VALID, 8'h2A);
      applyStimulus(8'h2A, 7, 0, 1'b1, 1'b1, 1'b1, 1'b0);
      idleBits(1);

      $display("[TB] glitch then 3C");
      data_bits_count  = 2'd3;
      parity_type      = 2'd0;
      double_stop_bits = 1'b0;
      rx = 1'b0;
      repeat (24) @(negedge clk);
      idleBits(2);
      checkOutput("busy_after_glitch", {7'd0, busy}, 8'd0);
      expectEvent(EV_VALID, 8'h3C);
      applyStimulus(8'h3C, 8, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      idleBits(1);

      $display("[TB] overrun and back-to-back");
      fifo_full = 1'b1;
      expectEvent(EV_OVR, 8'h00);
      applyStimulus(8'hFF, 8, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      fifo_full = 1'b0;
      idleBits(1);
      checkOutput("data_after_ovr", data, 8'h3C);
      expectEvent(EV_VALID, 8'h01);
      expectEvent(EV_VALID, 8'h80);
      applyStimulus(8'h01, 8, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h80, 8, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      idleBits(1);
      checkOutput("data_b2b", data, 8'h80);

      $display("[TB] reset mid-frame then 55");
      driveBit(1'b0);
      driveBit(1'b1);
      driveBit(1'b0);
      driveBit(1'b1);
      rx = 1'b0;
      repeat (BIT_CLKS / 2) @(negedge clk);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("midrst_data", data, 8'h00);
      checkOutput("midrst_busy", {7'd0, busy}, 8'd0);
      repeat (8) @(negedge clk);
      reset = 1'b0;
      idleBits(2);
      expectEvent(EV_VALID, 8'h55);
      applyStimulus(8'h55, 8, -1, 1'b1, 1'b1, 1'b0, 1'b0);
      idleBits(2);
      checkOutput("data_55", data, 8'h55);

      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("[TB] FAIL missing_pulses got=%0d outstanding want=0", expq.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
